// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared FSM state type and default widths for the APB
//               request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int c_DEF_NUM_REQ        = 4;
    localparam int c_DEF_PADDR_WIDTH    = 32;
    localparam int c_DEF_PWDATA_WIDTH   = 32;
    localparam int c_DEF_PRDATA_WIDTH   = 32;
    localparam int c_DEF_TIMEOUT_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Combinational round-robin pick; search begins at ptr and
//               skips masked requesters. Output is one-hot or zero.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    int                 w_idx;

    assign w_elig = req & ~mask;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = int'(ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && w_elig[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Shares one APB master among NUM_REQ requesters, round-robin.
//               Define APB_ARB_TIMEOUT_EN to bound ACCESS wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = c_DEF_NUM_REQ,
    parameter int PADDR_WIDTH    = c_DEF_PADDR_WIDTH,
    parameter int PWDATA_WIDTH   = c_DEF_PWDATA_WIDTH,
    parameter int PRDATA_WIDTH   = c_DEF_PRDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic                            pclock,
    input  logic                            preset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*PWDATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [PRDATA_WIDTH-1:0]         rsp_rdata,
    output logic                            rsp_err,
    output logic [PADDR_WIDTH-1:0]          paddr,
    output logic                            prwd,
    output logic [PWDATA_WIDTH-1:0]         pwdata,
    output logic                            psel,
    output logic                            penable,
    input  logic [PRDATA_WIDTH-1:0]         prdata,
    input  logic                            pslverr,
    input  logic                            pready
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_e r_state;
    apb_state_e w_state_nxt;

    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_done;
    logic [NUM_REQ-1:0]      w_pick;
    logic [NUM_REQ-1:0]      w_mask;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [c_PTR_W-1:0]      w_start;
    logic [c_PTR_W-1:0]      w_owner_idx;
    logic [c_PTR_W-1:0]      w_pick_idx;
    logic                    w_complete;
    logic                    w_timeout;
    logic                    w_load;
    logic [PADDR_WIDTH-1:0]  r_addr;
    logic [PWDATA_WIDTH-1:0] r_wdata;
    logic                    r_wr;
    logic [PRDATA_WIDTH-1:0] r_rdata;
    logic                    r_err;

    logic [PADDR_WIDTH-1:0]  w_addr_arr  [NUM_REQ];
    logic [PWDATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*PADDR_WIDTH +: PADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*PWDATA_WIDTH +: PWDATA_WIDTH];
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Counter sits at zero outside ACCESS, so every ACCESS entry starts fresh.
    always_ff @(posedge pclock) begin
        if (preset || (r_state != ACCESS)) begin
            r_to_cnt <= '0;
        end else if (!pready) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    assign w_timeout = (r_state == ACCESS) && !pready &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_complete = (r_state == ACCESS) && (pready || w_timeout);

    always_comb begin
        w_owner_idx = '0;
        w_pick_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_owner_idx = c_PTR_W'(i);
            end
            if (w_pick[i]) begin
                w_pick_idx = c_PTR_W'(i);
            end
        end
    end

    // The finishing owner (or the one just pulsed done) must not win again
    // while its req is still visible, otherwise it would get a duplicate.
    always_comb begin
        w_start = r_ptr;
        w_mask  = r_done;
        if (w_complete) begin
            w_mask  = r_gnt;
            w_start = (w_owner_idx == c_PTR_W'(NUM_REQ - 1)) ? '0
                    : (w_owner_idx + c_PTR_W'(1));
        end
    end

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr (
        .req  (req),
        .mask (w_mask),
        .ptr  (w_start),
        .gnt  (w_pick)
    );

    assign w_load = ((r_state == IDLE) || w_complete) && (|w_pick);

    always_ff @(posedge pclock) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|w_pick) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (w_complete) begin
                    w_state_nxt = (|w_pick) ? SETUP : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclock) begin
        if (preset) begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            if (w_complete) begin
                r_done  <= r_gnt;
                r_ptr   <= w_start;
                r_rdata <= (r_wr || !pready) ? '0 : prdata;
                r_err   <= pready ? pslverr : 1'b1;
            end
            if (w_load) begin
                r_gnt   <= w_pick;
                r_addr  <= w_addr_arr[w_pick_idx];
                r_wdata <= w_wdata_arr[w_pick_idx];
                r_wr    <= req_wr[w_pick_idx];
            end else if (w_complete) begin
                r_gnt <= '0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign paddr     = r_addr;
    assign pwdata    = r_wdata;
    assign prwd      = r_wr;
    assign psel      = (r_state != IDLE);
    assign penable   = (r_state == ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Self-checking bench for apb_req_arbiter (vector table,
//               directed sequences, randomized traffic vs. reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              pclock = 1'b0;
    logic              preset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      req_wr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     paddr;
    logic              prwd;
    logic [DW-1:0]     pwdata;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     prdata = '0;
    logic              pslverr = 1'b0;
    logic              pready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 pclock = ~pclock;

    apb_req_arbiter #(
        .NUM_REQ        (N),
        .PADDR_WIDTH    (AW),
        .PWDATA_WIDTH   (DW),
        .PRDATA_WIDTH   (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclock    (pclock),
        .preset    (preset),
        .req       (req),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .prwd      (prwd),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .pready    (pready)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic          wr;
        logic [AW-1:0] base;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [N-1:0]  e_gnt;
        logic [AW-1:0] e_paddr;
        logic [DW-1:0] e_pwdata;
        logic [DW-1:0] e_rdata;
        logic          e_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclock);
        #1;
    endtask

    task automatic do_reset();
        preset  = 1'b1;
        req     = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        step();
        step();
        preset = 1'b0;
    endtask

    // Requester i gets address base+4*i and write data wdata+i.
    task automatic set_slices(input logic [AW-1:0] base, input logic wr, input logic [DW-1:0] wd);
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = base + AW'(4 * i);
            req_wdata[i*DW +: DW] = wd + DW'(i);
            req_wr[i]             = wr;
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Reference model state for the random phase
    int            m_phase;
    int            m_owner;
    int            m_last;
    int            w;
    logic [N-1:0]  pend;
    logic [N-1:0]  e_done;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    logic [N-1:0]  p_req;
    logic          p_pready;
    logic [DW-1:0] p_prdata;
    logic          p_slverr;
    logic [AW-1:0] ra [N];
    logic [DW-1:0] rd [N];
    logic          rw [N];
    int            acc;
    logic          seen;

    initial begin
        vecs[0] = '{4'b0001, 1'b1, 32'h0000_0010, 32'h0000_00A5, 32'h1111_1111, 1'b0,
                    4'b0001, 32'h0000_0010, 32'h0000_00A5, 32'h0000_0000, 1'b0};
        vecs[1] = '{4'b0010, 1'b0, 32'h0000_2000, 32'h0000_0055, 32'h1234_5678, 1'b0,
                    4'b0010, 32'h0000_2004, 32'h0000_0056, 32'h1234_5678, 1'b0};
        vecs[2] = '{4'b1100, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'hCAFE_F00D, 1'b1,
                    4'b0100, 32'h0000_0408, 32'h0000_0002, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{4'b1000, 1'b1, 32'hFFFF_FFF0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                    4'b1000, 32'hFFFF_FFFC, 32'h8000_0003, 32'h0000_0000, 1'b1};
        vecs[4] = '{4'b1010, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'h0BAD_BEEF, 1'b0,
                    4'b0010, 32'h0000_0004, 32'h0000_0011, 32'h0BAD_BEEF, 1'b0};
        vecs[5] = '{4'b1111, 1'b1, 32'h0000_0100, 32'h0000_0007, 32'h0000_0005, 1'b0,
                    4'b0001, 32'h0000_0100, 32'h0000_0007, 32'h0000_0000, 1'b0};

        // Reset state
        do_reset();
        check("rst_psel_penable_prwd", {psel, penable, prwd}, 3'b000);
        check("rst_gnt_done", {gnt, done}, 8'h00);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);

        // Vector table: single transfer from IDLE, minimum latency
        foreach (vecs[v]) begin
            do_reset();
            set_slices(vecs[v].base, vecs[v].wr, vecs[v].wdata);
            req     = vecs[v].req;
            pready  = 1'b1;
            prdata  = vecs[v].prdata;
            pslverr = vecs[v].slverr;
            step();
            check($sformatf("vec%0d_setup", v), {psel, penable}, 2'b10);
            check($sformatf("vec%0d_gnt", v), gnt, vecs[v].e_gnt);
            check($sformatf("vec%0d_paddr", v), paddr, vecs[v].e_paddr);
            check($sformatf("vec%0d_pwdata", v), pwdata, vecs[v].e_pwdata);
            check($sformatf("vec%0d_prwd", v), prwd, vecs[v].wr);
            check($sformatf("vec%0d_done_early", v), done, 4'b0);
            step();
            check($sformatf("vec%0d_access", v), {psel, penable}, 2'b11);
            step();
            check($sformatf("vec%0d_done", v), done, vecs[v].e_gnt);
            check($sformatf("vec%0d_rdata", v), rsp_rdata, vecs[v].e_rdata);
            check($sformatf("vec%0d_err", v), rsp_err, vecs[v].e_err);
            check($sformatf("vec%0d_next_psel", v), psel, (vecs[v].req & ~vecs[v].e_gnt) != 0);
        end

        // All four held, pready high: grant order 0,1,2,3,0 back-to-back
        do_reset();
        set_slices(32'h0000_5000, 1'b1, 32'h0);
        req    = 4'b1111;
        pready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr%0d_setup", k), {psel, penable}, 2'b10);
            check($sformatf("rr%0d_gnt", k), gnt, 4'b0001 << (k % 4));
            if (k > 0) check($sformatf("rr%0d_done_prev", k), done, 4'b0001 << ((k - 1) % 4));
            step();
            check($sformatf("rr%0d_access", k), {psel, penable}, 2'b11);
        end

        // Read with three wait states and slave error
        do_reset();
        set_slices(32'h0000_0A00, 1'b0, 32'h0);
        req     = 4'b0001;
        pready  = 1'b0;
        prdata  = 32'hDEAD_BEEF;
        pslverr = 1'b1;
        step();
        check("ws_setup", {psel, penable}, 2'b10);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ws_access%0d", k), {psel, penable}, 2'b11);
            check($sformatf("ws_paddr%0d", k), paddr, 32'h0000_0A00);
            check($sformatf("ws_nodone%0d", k), done, 4'b0);
            if (k == 3) pready = 1'b1;
        end
        step();
        check("ws_done", done, 4'b0001);
        check("ws_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("ws_err", rsp_err, 1'b1);

        // req dropped during SETUP: transfer still completes
        do_reset();
        set_slices(32'h0000_0B00, 1'b1, 32'h0000_0077);
        req     = 4'b0010;
        pready  = 1'b1;
        pslverr = 1'b0;
        step();
        req = 4'b0000;
        step();
        check("drop_access", {psel, penable}, 2'b11);
        step();
        check("drop_done", done, 4'b0010);
        check("drop_idle", psel, 1'b0);

        // Reset during ACCESS aborts without done
        do_reset();
        set_slices(32'h0000_0C00, 1'b1, 32'h0);
        req    = 4'b0001;
        pready = 1'b0;
        step();
        step();
        check("abort_in_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        step();
        check("abort_psel_gnt", {psel, gnt}, 5'b0);
        check("abort_done", done, 4'b0);
        preset = 1'b0;
        step();
        check("abort_no_done", done, 4'b0);
        check("abort_resume", {psel, penable, gnt}, {2'b10, 4'b0001});

        // Stuck-low pready
        do_reset();
        set_slices(32'h0000_0D00, 1'b0, 32'h0);
        req     = 4'b0001;
        pready  = 1'b0;
        prdata  = 32'h1234_5678;
        pslverr = 1'b0;
        acc     = 0;
        seen    = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        for (int c = 0; c < 120; c++) begin
            step();
            if (done != 0) begin
                if (!seen) begin
                    check("to_done", done, 4'b0001);
                    check("to_rdata", rsp_rdata, 32'h0);
                    check("to_err", rsp_err, 1'b1);
                end
                seen = 1'b1;
                req  = 4'b0000;
            end else if (psel && penable && !seen) begin
                acc++;
            end
        end
        check("to_seen", seen, 1'b1);
        check("to_access_cycles", acc, 16);
`else
        for (int c = 0; c < 100; c++) begin
            step();
            if (done != 0) seen = 1'b1;
        end
        check("nto_no_done", seen, 1'b0);
        check("nto_still_access", {psel, penable}, 2'b11);
`endif

        // Randomized traffic against the reference model
        do_reset();
        m_phase = 0;
        m_owner = 0;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rd[i] = '0;
            rw[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 3 == 0)) begin
                    ra[i]  = $urandom;
                    rd[i]  = $urandom;
                    rw[i]  = 1'($urandom % 2);
                    req[i] = 1'b1;
                end
                req_addr[i*AW +: AW]  = ra[i];
                req_wdata[i*DW +: DW] = rd[i];
                req_wr[i]             = rw[i];
            end
            pready   = ($urandom % 4) != 0;
            prdata   = $urandom;
            pslverr  = 1'($urandom % 2);
            p_req    = req;
            p_pready = pready;
            p_prdata = prdata;
            p_slverr = pslverr;
            step();

            e_done  = '0;
            e_rdata = '0;
            e_err   = 1'b0;
            if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 0 || p_pready) begin
                pend = p_req;
                if (m_phase == 2) begin
                    e_done  = 4'b0001 << m_owner;
                    e_rdata = rw[m_owner] ? '0 : p_prdata;
                    e_err   = p_slverr;
                    m_last  = m_owner;
                    pend    = pend & ~e_done;
                end
                w = rr_pick(pend, m_last);
                if (w >= 0) begin
                    m_phase = 1;
                    m_owner = w;
                end else begin
                    m_phase = 0;
                end
            end

            check("rnd_psel", psel, m_phase != 0);
            check("rnd_penable", penable, m_phase == 2);
            check("rnd_gnt", gnt, (m_phase != 0) ? (4'b0001 << m_owner) : 4'b0000);
            check("rnd_done", done, e_done);
            if (e_done != 0) begin
                check("rnd_rdata", rsp_rdata, e_rdata);
                check("rnd_err", rsp_err, e_err);
            end
            if (m_phase != 0) begin
                check("rnd_paddr", paddr, ra[m_owner]);
                check("rnd_prwd", prwd, rw[m_owner]);
                check("rnd_pwdata", pwdata, rd[m_owner]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
